branch_predict_ctrl: RTL and testbench
======================================

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 The block SHALL have parameter IDX_BITS, default 4: the predictor table holds 2^IDX_BITS entries, indexed by pc[IDX_BITS+1:2].
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2: the total number of non-stalled cycles flush_o is held after a redirect (legal range 1..15).
REQ-003 clk  in  1  single clock, rising edge; all state changes here.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 stall_i  in  1  pipeline stall; freezes updates and the flush countdown.
REQ-006 if_pc_i  in  32  PC of the instruction being fetched.
REQ-007 pred_taken_o  out  1  prediction for if_pc_i (1 = taken).
REQ-008 ex_valid_i  in  1  a branch or jump is resolving in EX this cycle.
REQ-009 ex_is_branch_i  in  1  1 = conditional branch, 0 = JAL/JALR.
REQ-010 ex_pc_i  in  32  PC of the resolving instruction.
REQ-011 ex_pcsrc_i  in  2  resolved PC source: 00 = PC+4, 01 = PC+imm, 10 = ALUResult (JALR).
REQ-012 ex_pred_taken_i  in  1  prediction carried down the pipe with this instruction.
REQ-013 redirect_o  out  1  fetch SHALL take the PC selected by redirect_sel_o this cycle.
REQ-014 redirect_sel_o  out  2  PC source to apply; encoding as ex_pcsrc_i.
REQ-015 recover_pc_o  out  32  ex_pc_i + 4, used when redirect_sel_o = 00.
REQ-016 flush_o  out  1  kill the wrong-path instructions in IF/ID and ID/EX.
REQ-017 busy_o  out  1  1 while in state FLUSH.

Function
REQ-018 Each table entry SHALL be a 2-bit saturating counter; pred_taken_o SHALL be counter[1] of the entry indexed by if_pc_i, combinational, with no write bypass (a same-cycle write is seen on the next cycle).
REQ-019 A resolve SHALL be accepted only when ex_valid_i=1, stall_i=0 and the state is IDLE; otherwise ex_valid_i SHALL be ignored.
REQ-020 For an accepted branch, actual_taken SHALL be (ex_pcsrc_i==01), and the entry at ex_pc_i SHALL increment (saturating at 11) if taken and decrement (saturating at 00) if not.
REQ-021 A branch mispredicts when actual_taken != ex_pred_taken_i; every accepted jump (ex_is_branch_i=0) SHALL be treated as a mispredict and SHALL NOT update the table.
REQ-022 On a mispredict, redirect_o and flush_o SHALL both be 1 in the same cycle, combinationally; redirect_sel_o SHALL equal ex_pcsrc_i.
REQ-023 When redirect_o=0, redirect_sel_o SHALL be 00.
REQ-024 The FSM SHALL have two states, IDLE and FLUSH. On a mispredict with FLUSH_CYCLES>1 it SHALL go IDLE->FLUSH, loading cnt=FLUSH_CYCLES-1; with FLUSH_CYCLES=1 it SHALL stay in IDLE.
REQ-025 In FLUSH, flush_o SHALL be 1 and redirect_o SHALL be 0; cnt SHALL decrement on each cycle with stall_i=0, and the FSM SHALL return to IDLE on the cycle cnt decrements from 1 to 0.
REQ-026 A correctly predicted branch SHALL update the table only, with redirect_o=0 and flush_o=0.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL clear all table entries to 01 (weakly not-taken), set the state to IDLE and set cnt to 0, aborting any flush in progress.
REQ-028 The next cycle after reset SHALL have flush_o=0, redirect_o=0 and busy_o=0, and pred_taken_o SHALL read 0 for every PC.

Configuration
REQ-029 The macro BP_STATS_EN SHALL control the statistics outputs.
- Defined: add outputs stat_branches_o[15:0] and stat_mispred_o[15:0]; each counts accepted branches / branch mispredicts only, saturates at 0xFFFF and resets to 0.
- Undefined: neither port nor its counters SHALL exist.

Structure
REQ-030 A shared package bp_pkg SHALL hold the state enum (IDLE, FLUSH), the PC-source encodings (PCSRC_PLUS4, PCSRC_TARGET, PCSRC_JALR) and the counter reset value CNT_RESET=2'b01.
REQ-031 The counter table SHALL be the single sub-module bp_table (one combinational read port, one synchronous write port).

Verification
REQ-032 After reset, if_pc_i=0x40 -> pred_taken_o=0; a branch at ex_pc=0x40 with ex_pcsrc=01 and pred=0 -> redirect_o=1, redirect_sel_o=01, flush_o=1, then flush_o=1 for exactly 1 more cycle.
REQ-033 Three taken branches at 0x40 -> counter 01->10->11->11; the prediction for 0x40 reads 1 after the first update; a branch at 0x80 (same index with IDX_BITS=4) shares the entry.
REQ-034 pred=1 and ex_pcsrc=00 at ex_pc=0x100 -> redirect_sel_o=00, recover_pc_o=0x104, counter decremented.
REQ-035 JALR with ex_pcsrc=10 -> redirect_sel_o=10 and the table is unchanged; ex_valid_i=1 during FLUSH -> ignored, no update.
REQ-036 stall_i=1 for 3 cycles mid-FLUSH -> flush_o stays 1 and the return to IDLE is delayed by 3 cycles; rst_n=0 mid-FLUSH -> busy_o=0 next cycle.
REQ-037 With BP_STATS_EN defined: 5 branches, 2 of them mispredicted -> stat_branches_o=5 and stat_mispred_o=2; jumps are not counted.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_pkg : shared state, PC-source and counter definitions for branch_predict_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bp_state_e;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [1:0] CNT_RESET = 2'b01;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] r;
    r = cnt;
    if (taken && (cnt != 2'b11)) begin
      r = cnt + 2'd1;
    end else if (!taken && (cnt != 2'b00)) begin
      r = cnt - 2'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_table : 2-bit saturating counter table, one async read, one sync update
// Rev 1.0
// ---------------------------------------------------------------------------
module bp_table
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_cnt,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int c_entries = 1 << IDX_BITS;

  logic [1:0] r_cnt [c_entries];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_entries; i++) begin
        r_cnt[i] <= CNT_RESET;
      end
    end else if (upd_en) begin
      r_cnt[upd_idx] <= sat_update(r_cnt[upd_idx], upd_taken);
    end
  end

  // No write bypass: an update lands after the edge and is read next cycle
  assign rd_cnt = r_cnt[rd_idx];

endmodule
`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predict_ctrl : bimodal predictor with mispredict redirect/flush FSM
// Optional statistics counters: define BP_STATS_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic [31:0] if_pc_i,
  output logic        pred_taken_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic [1:0]  ex_pcsrc_i,
  input  logic        ex_pred_taken_i,
  output logic        redirect_o,
  output logic [1:0]  redirect_sel_o,
  output logic [31:0] recover_pc_o,
  output logic        flush_o,
`ifdef BP_STATS_EN
  output logic [15:0] stat_branches_o,
  output logic [15:0] stat_mispred_o,
`endif
  output logic        busy_o
);

  localparam logic [3:0] c_cnt_load = 4'(FLUSH_CYCLES - 1);

  bp_state_e  r_state;
  bp_state_e  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_accept;
  logic       w_taken;
  logic       w_mispred;
  logic [1:0] w_entry;
  logic       w_unused;

  assign w_unused = ^{if_pc_i[31:IDX_BITS+2], if_pc_i[1:0]};

  bp_table #(
    .IDX_BITS (IDX_BITS)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc_i[IDX_BITS+1:2]),
    .rd_cnt    (w_entry),
    .upd_en    (w_accept & ex_is_branch_i),
    .upd_idx   (ex_pc_i[IDX_BITS+1:2]),
    .upd_taken (w_taken)
  );

  assign pred_taken_o = w_entry[1];
  assign recover_pc_o = ex_pc_i + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_accept       = ex_valid_i & ~stall_i & (r_state == IDLE);
    w_taken        = (ex_pcsrc_i == PCSRC_TARGET);
    // Jumps are never predicted, so every accepted jump redirects
    w_mispred      = w_accept & (~ex_is_branch_i | (w_taken != ex_pred_taken_i));
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    redirect_o     = w_mispred;
    redirect_sel_o = w_mispred ? ex_pcsrc_i : PCSRC_PLUS4;
    flush_o        = w_mispred;
    busy_o         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mispred && (FLUSH_CYCLES > 1)) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = c_cnt_load;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        busy_o  = 1'b1;
        if (!stall_i) begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef BP_STATS_EN
  logic [15:0] r_stat_br;
  logic [15:0] r_stat_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_br  <= 16'd0;
      r_stat_mis <= 16'd0;
    end else begin
      if (w_accept && ex_is_branch_i && (r_stat_br != 16'hFFFF)) begin
        r_stat_br <= r_stat_br + 16'd1;
      end
      if (w_mispred && ex_is_branch_i && (r_stat_mis != 16'hFFFF)) begin
        r_stat_mis <= r_stat_mis + 16'd1;
      end
    end
  end

  assign stat_branches_o = r_stat_br;
  assign stat_mispred_o  = r_stat_mis;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl : directed scenarios plus randomized model comparison
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [31:0] ex_pc_i;
  logic [1:0]  ex_pcsrc_i;
  logic        ex_pred_taken_i;
  logic        redirect_o;
  logic [1:0]  redirect_sel_o;
  logic [31:0] recover_pc_o;
  logic        flush_o;
  logic        busy_o;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches_o;
  logic [15:0] stat_mispred_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt [16];
  int m_flush_left;
  int m_br;
  int m_mis;

  always #5 clk = ~clk;

  branch_predict_ctrl #(
    .IDX_BITS     (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .if_pc_i         (if_pc_i),
    .pred_taken_o    (pred_taken_o),
    .ex_valid_i      (ex_valid_i),
    .ex_is_branch_i  (ex_is_branch_i),
    .ex_pc_i         (ex_pc_i),
    .ex_pcsrc_i      (ex_pcsrc_i),
    .ex_pred_taken_i (ex_pred_taken_i),
    .redirect_o      (redirect_o),
    .redirect_sel_o  (redirect_sel_o),
    .recover_pc_o    (recover_pc_o),
    .flush_o         (flush_o),
`ifdef BP_STATS_EN
    .stat_branches_o (stat_branches_o),
    .stat_mispred_o  (stat_mispred_o),
`endif
    .busy_o          (busy_o)
  );

  task automatic drive(input logic v, input logic br, input logic [31:0] pc,
                       input logic [1:0] src, input logic pr);
    ex_valid_i      = v;
    ex_is_branch_i  = br;
    ex_pc_i         = pc;
    ex_pcsrc_i      = src;
    ex_pred_taken_i = pr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    stall_i = 1'b0;
    if_pc_i = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if_pc_i = 32'(i) << 2;
      #1;
      n_tests++;
      if (pred_taken_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_pred idx=%0d got=%b want=0", i, pred_taken_o);
      end
      n_tests++;
      if ({redirect_o, flush_o, busy_o, redirect_sel_o} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl got red/fl/busy/sel=%b want=00000",
                 {redirect_o, flush_o, busy_o, redirect_sel_o});
      end
      tick();
    end
  endtask

  task automatic test_mispredict_flush;
    do_reset();
    if_pc_i = 32'h40;
    drive(1'b1, 1'b1, 32'h40, 2'b01, 1'b0);
    #1;
    n_tests++;
    if ({redirect_o, redirect_sel_o, flush_o, busy_o} !== 5'b10110) begin
      n_fail++;
      $display("FAIL mis_cycle got red/sel/fl/busy=%b want=10110",
               {redirect_o, redirect_sel_o, flush_o, busy_o});
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    #1;
    n_tests++;
    if ({redirect_o, redirect_sel_o, flush_o, busy_o, pred_taken_o} !== 6'b000111) begin
      n_fail++;
      $display("FAIL mis_flush1 got red/sel/fl/busy/pred=%b want=000111",
               {redirect_o, redirect_sel_o, flush_o, busy_o, pred_taken_o});
    end
    tick();
    #1;
    n_tests++;
    if ({flush_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_done got fl/busy=%b want=00", {flush_o, busy_o});
    end
  endtask

  task automatic test_saturate_alias;
    do_reset();
    if_pc_i = 32'h80;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h40, 2'b01, 1'b1);
      #1;
      n_tests++;
      if ({redirect_o, flush_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL sat_correct k=%0d got red/fl=%b want=00", k, {redirect_o, flush_o});
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
      #1;
      n_tests++;
      if (pred_taken_o !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_pred k=%0d got=%b want=1", k, pred_taken_o);
      end
    end
    drive(1'b1, 1'b1, 32'h80, 2'b00, 1'b1);
    #1;
    n_tests++;
    if (redirect_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_nt_redirect got=%b want=1", redirect_o);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    #1;
    n_tests++;
    if (pred_taken_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_dec1 got=%b want=1", pred_taken_o);
    end
    drive(1'b1, 1'b1, 32'h80, 2'b00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    #1;
    n_tests++;
    if (pred_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_dec2 got=%b want=0", pred_taken_o);
    end
  endtask

  task automatic test_not_taken;
    do_reset();
    if_pc_i = 32'h100;
    drive(1'b1, 1'b1, 32'h100, 2'b00, 1'b1);
    #1;
    n_tests++;
    if ({redirect_o, redirect_sel_o, flush_o} !== 4'b1001 || recover_pc_o !== 32'h104) begin
      n_fail++;
      $display("FAIL nt_redirect got red/sel/fl=%b rec=%h want=1001 rec=00000104",
               {redirect_o, redirect_sel_o, flush_o}, recover_pc_o);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h100, 2'b01, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    #1;
    n_tests++;
    if (pred_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL nt_decrement got=%b want=0", pred_taken_o);
    end
  endtask

  task automatic test_jalr_ignore;
    do_reset();
    if_pc_i = 32'h40;
    drive(1'b1, 1'b0, 32'h40, 2'b10, 1'b1);
    #1;
    n_tests++;
    if ({redirect_o, redirect_sel_o, flush_o} !== 4'b1101) begin
      n_fail++;
      $display("FAIL jalr_redirect got red/sel/fl=%b want=1101",
               {redirect_o, redirect_sel_o, flush_o});
    end
    tick();
    drive(1'b1, 1'b1, 32'h40, 2'b01, 1'b0);
    #1;
    n_tests++;
    if ({redirect_o, redirect_sel_o, flush_o, busy_o} !== 5'b00011) begin
      n_fail++;
      $display("FAIL flush_ignore got red/sel/fl/busy=%b want=00011",
               {redirect_o, redirect_sel_o, flush_o, busy_o});
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    #1;
    n_tests++;
    if ({busy_o, pred_taken_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_noupd got busy/pred=%b want=00", {busy_o, pred_taken_o});
    end
    drive(1'b1, 1'b1, 32'h40, 2'b01, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    #1;
    n_tests++;
    if (pred_taken_o !== 1'b1) begin
      n_fail++;
      $display("FAIL jalr_noupd got=%b want=1", pred_taken_o);
    end
  endtask

  task automatic test_stall_flush;
    do_reset();
    drive(1'b1, 1'b1, 32'h40, 2'b01, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if ({flush_o, busy_o} !== 2'b11) begin
        n_fail++;
        $display("FAIL stall_hold k=%0d got fl/busy=%b want=11", k, {flush_o, busy_o});
      end
      tick();
    end
    stall_i = 1'b0;
    #1;
    n_tests++;
    if ({flush_o, busy_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL stall_last got fl/busy=%b want=11", {flush_o, busy_o});
    end
    tick();
    #1;
    n_tests++;
    if ({flush_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_exit got fl/busy=%b want=00", {flush_o, busy_o});
    end
    drive(1'b1, 1'b1, 32'h40, 2'b00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({flush_o, busy_o, redirect_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_abort got fl/busy/red=%b want=000", {flush_o, busy_o, redirect_o});
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats;
    logic [1:0] srcs [5] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    logic       prs  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    n_tests++;
    if ({stat_branches_o, stat_mispred_o} !== 32'h0) begin
      n_fail++;
      $display("FAIL stats_reset got br=%0d mis=%0d want 0 0", stat_branches_o, stat_mispred_o);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 32'(k) << 2, srcs[k], prs[k]);
      tick();
      drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
      tick();
      tick();
    end
    drive(1'b1, 1'b0, 32'h20, 2'b10, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    #1;
    n_tests++;
    if (stat_branches_o !== 16'd5 || stat_mispred_o !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_count got br=%0d mis=%0d want 5 2", stat_branches_o, stat_mispred_o);
    end
  endtask
`endif

  task automatic test_random;
    logic        v, br, pr, acc, tk, mis;
    logic [1:0]  src;
    logic [31:0] epc, ipc;
    logic [5:0]  exp_v, got_v;
    int          ii, ie;
    do_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 1;
    m_flush_left = 0;
    m_br  = 0;
    m_mis = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      stall_i = ($urandom_range(0, 4) == 0);
      v   = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 3) != 0);
      src = br ? 2'($urandom_range(0, 1)) : 2'($urandom_range(1, 2));
      pr  = 1'($urandom_range(0, 1));
      epc = 32'($urandom_range(0, 255)) << 2;
      ipc = $urandom & 32'hFFFF_FFFC;
      drive(v, br, epc, src, pr);
      if_pc_i = ipc;
      #1;
      ii  = int'((ipc >> 2) % 16);
      ie  = int'((epc >> 2) % 16);
      acc = v && !stall_i && (m_flush_left == 0);
      tk  = (src == 2'b01);
      mis = acc && (!br || (tk != pr));
      exp_v = {mis, mis ? src : 2'b00, mis || (m_flush_left > 0), m_flush_left > 0, m_cnt[ii] >= 2};
      got_v = {redirect_o, redirect_sel_o, flush_o, busy_o, pred_taken_o};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d got red/sel/fl/busy/pred=%b want=%b", c, got_v, exp_v);
      end
      n_tests++;
      if (recover_pc_o !== epc + 32'd4) begin
        n_fail++;
        $display("FAIL rand_recover cyc=%0d got=%h want=%h", c, recover_pc_o, epc + 32'd4);
      end
`ifdef BP_STATS_EN
      n_tests++;
      if (stat_branches_o !== 16'(m_br) || stat_mispred_o !== 16'(m_mis)) begin
        n_fail++;
        $display("FAIL rand_stats cyc=%0d got br=%0d mis=%0d want %0d %0d",
                 c, stat_branches_o, stat_mispred_o, m_br, m_mis);
      end
`endif
      tick();
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
        m_flush_left = 0;
        m_br  = 0;
        m_mis = 0;
      end else begin
        if (acc && br) begin
          m_cnt[ie] = tk ? ((m_cnt[ie] < 3) ? m_cnt[ie] + 1 : 3)
                         : ((m_cnt[ie] > 0) ? m_cnt[ie] - 1 : 0);
          m_br++;
          if (mis) m_mis++;
        end
        if (m_flush_left > 0) begin
          if (!stall_i) m_flush_left--;
        end else if (mis) begin
          m_flush_left = 1;
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mispredict_flush();
    test_saturate_alias();
    test_not_taken();
    test_jalr_ignore();
    test_stall_flush();
`ifdef BP_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
